// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage back end: condition codes, branch/cmov condition, M pipeline register.
// Define EXEC_PERF_CNT_EN to build the CC-update and untaken-jXX performance counters.
module execute_cc_stage #(
    parameter int         W        = 64,
    parameter logic [3:0] REG_NONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [2:0]   E_stat,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [W-1:0] e_valE,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         e_Cnd,
    output logic [3:0]   e_dstE,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of,
    output logic [3:0]   M_icode,
    output logic [2:0]   M_stat,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic         frozen,
    output logic [31:0]  perf_updates,
    output logic [31:0]  perf_untaken
);

    localparam logic [3:0] ICODE_NOP   = 4'h1;
    localparam logic [3:0] ICODE_CMOVX = 4'h2;
    localparam logic [3:0] ICODE_OPQ   = 4'h6;
    localparam logic [3:0] ICODE_JXX   = 4'h7;
    localparam logic [2:0] STAT_AOK    = 3'd1;
    localparam logic [2:0] STAT_HLT    = 3'd2;
    localparam logic [2:0] STAT_ADR    = 3'd3;
    localparam logic [2:0] STAT_INS    = 3'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic         m_exc, w_exc;
    logic         set_cc;
    logic         new_zf, new_sf, new_of;
    logic         zf_q, sf_q, of_q;
    logic         zf_d, sf_d, of_d;
    logic         a_msb, b_msb, r_msb;

    logic [3:0]   m_icode_q, m_icode_d;
    logic [2:0]   m_stat_q, m_stat_d;
    logic         m_cnd_q, m_cnd_d;
    logic [W-1:0] m_vale_q, m_vale_d;
    logic [W-1:0] m_vala_q, m_vala_d;
    logic [3:0]   m_dste_q, m_dste_d;
    logic [3:0]   m_dstm_q, m_dstm_d;

    // An exception status anywhere downstream must stop this instruction from touching the CCs.
    always_comb begin
        m_exc = (m_stat == STAT_HLT) || (m_stat == STAT_ADR) || (m_stat == STAT_INS);
        w_exc = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (m_exc || w_exc) state_d = ST_FROZEN;
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        frozen = (state_q == ST_FROZEN);
        set_cc = (E_icode == ICODE_OPQ) && (state_q == ST_RUN) && !m_exc && !w_exc;
    end

    always_comb begin
        a_msb  = alu_a[W-1];
        b_msb  = alu_b[W-1];
        r_msb  = e_valE[W-1];
        new_zf = (e_valE == '0);
        new_sf = r_msb;
        case (E_ifun)
            4'h0:    new_of = (a_msb == b_msb) && (r_msb != b_msb);
            4'h1:    new_of = (a_msb != b_msb) && (r_msb != b_msb);
            default: new_of = 1'b0;
        endcase
    end

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (set_cc) begin
            zf_d = new_zf;
            sf_d = new_sf;
            of_d = new_of;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign cc_zf = zf_q;
    assign cc_sf = sf_q;
    assign cc_of = of_q;

    // Condition uses the CC value from before this instruction's own update.
    always_comb begin
        case (E_ifun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = (sf_q ^ of_q) | zf_q;
            4'h2:    e_Cnd = sf_q ^ of_q;
            4'h3:    e_Cnd = zf_q;
            4'h4:    e_Cnd = !zf_q;
            4'h5:    e_Cnd = !(sf_q ^ of_q);
            4'h6:    e_Cnd = !(sf_q ^ of_q) && !zf_q;
            default: e_Cnd = 1'b0;
        endcase
        e_dstE = ((E_icode == ICODE_CMOVX) && !e_Cnd) ? REG_NONE : E_dstE;
    end

    always_comb begin
        m_icode_d = m_icode_q;
        m_stat_d  = m_stat_q;
        m_cnd_d   = m_cnd_q;
        m_vale_d  = m_vale_q;
        m_vala_d  = m_vala_q;
        m_dste_d  = m_dste_q;
        m_dstm_d  = m_dstm_q;
        if (M_stall) begin
            m_icode_d = m_icode_q;
        end else if (M_bubble) begin
            m_icode_d = ICODE_NOP;
            m_stat_d  = STAT_AOK;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = REG_NONE;
            m_dstm_d  = REG_NONE;
        end else begin
            m_icode_d = E_icode;
            m_stat_d  = E_stat;
            m_cnd_d   = e_Cnd;
            m_vale_d  = e_valE;
            m_vala_d  = E_valA;
            m_dste_d  = e_dstE;
            m_dstm_d  = E_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_icode_q <= ICODE_NOP;
            m_stat_q  <= STAT_AOK;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= REG_NONE;
            m_dstm_q  <= REG_NONE;
        end else begin
            m_icode_q <= m_icode_d;
            m_stat_q  <= m_stat_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign M_icode = m_icode_q;
    assign M_stat  = m_stat_q;
    assign M_Cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_updates_q, perf_updates_d;
    logic [31:0] perf_untaken_q, perf_untaken_d;

    // Untaken branches are only counted when the jXX actually enters M.
    always_comb begin
        perf_updates_d = perf_updates_q;
        perf_untaken_d = perf_untaken_q;
        if (set_cc) begin
            perf_updates_d = perf_updates_q + 32'd1;
        end
        if (!M_stall && !M_bubble && (E_icode == ICODE_JXX) && !e_Cnd) begin
            perf_untaken_d = perf_untaken_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_updates_q <= '0;
            perf_untaken_q <= '0;
        end else begin
            perf_updates_q <= perf_updates_d;
            perf_untaken_q <= perf_untaken_d;
        end
    end

    assign perf_updates = perf_updates_q;
    assign perf_untaken = perf_untaken_q;
`else
    assign perf_updates = 32'd0;
    assign perf_untaken = 32'd0;
`endif

endmodule
